// File: rtl/muldiv_unit_if.sv
// Handshake/data bundle between the execute stage and the multiply/divide unit.
// The master side drives operands and MTHI/MTLO strobes; the slave side returns HI/LO and status.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             mul0_div1_sel;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, mul0_div1_sel, is_signed, a, b, wr_hi, wr_lo, wd,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, mul0_div1_sel, is_signed, a, b, wr_hi, wr_lo, wd,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO pair.
// Optional MULDIV_EARLY_ZERO_EN: trivially-zero operations skip RUN and go straight to FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]        LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        CNT1   = CW'(1);
  localparam logic [WIDTH-1:0]     ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]     ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]     ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0]   ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   orig_a_r;
  logic               op_div_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               dz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               dz_out_r;

  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic               early_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_trial_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  // Operand magnitudes and the optional trivially-zero detection at start.
  always_comb begin
    a_neg_s = bus.is_signed & bus.a[WIDTH-1];
    b_neg_s = bus.is_signed & bus.b[WIDTH-1];
    if (a_neg_s) begin
      a_mag_s = (~bus.a) + ONE_W;
    end else begin
      a_mag_s = bus.a;
    end
    if (b_neg_s) begin
      b_mag_s = (~bus.b) + ONE_W;
    end else begin
      b_mag_s = bus.b;
    end
`ifdef MULDIV_EARLY_ZERO_EN
    if (bus.mul0_div1_sel) begin
      early_s = (bus.a == ZERO_W) && (bus.b != ZERO_W);
    end else begin
      early_s = (bus.a == ZERO_W) || (bus.b == ZERO_W);
    end
`else
    early_s = 1'b0;
`endif
  end

  // One iteration step; acc_r holds {upper, lower} for both multiply and divide.
  always_comb begin
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, mcand_r};
    // Bit WIDTH of the trial difference is set exactly when the subtraction underflowed.
    if (!div_trial_s[WIDTH]) begin
      div_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and result selection applied in FIX.
  always_comb begin
    if (neg_q_r) begin
      prod_s = (~acc_r) + ONE_2W;
      quo_s  = (~acc_r[WIDTH-1:0]) + ONE_W;
    end else begin
      prod_s = acc_r;
      quo_s  = acc_r[WIDTH-1:0];
    end
    if (neg_r_r) begin
      rem_s = (~acc_r[2*WIDTH-1:WIDTH]) + ONE_W;
    end else begin
      rem_s = acc_r[2*WIDTH-1:WIDTH];
    end
    if (dz_r) begin
      fix_hi_s = orig_a_r;
      fix_lo_s = ONES_W;
    end else if (op_div_r) begin
      fix_hi_s = rem_s;
      fix_lo_s = quo_s;
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Sequencer FSM with HI/LO, busy, done and div_by_zero registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= ZERO_W;
      orig_a_r <= ZERO_W;
      op_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dz_r     <= 1'b0;
      hi_r     <= ZERO_W;
      lo_r     <= ZERO_W;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dz_out_r <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      dz_out_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.wr_hi) hi_r <= bus.wd;
          if (bus.wr_lo) lo_r <= bus.wd;
          if (bus.start) begin
            busy_r   <= 1'b1;
            cnt_r    <= {CW{1'b0}};
            op_div_r <= bus.mul0_div1_sel;
            orig_a_r <= bus.a;
            if (early_s) begin
              state_r <= FIX;
              acc_r   <= {(2*WIDTH){1'b0}};
              neg_q_r <= 1'b0;
              neg_r_r <= 1'b0;
              dz_r    <= 1'b0;
            end else begin
              state_r <= RUN;
              neg_q_r <= a_neg_s ^ b_neg_s;
              neg_r_r <= a_neg_s;
              dz_r    <= bus.mul0_div1_sel & (bus.b == ZERO_W);
              if (bus.mul0_div1_sel) begin
                acc_r   <= {ZERO_W, a_mag_s};
                mcand_r <= b_mag_s;
              end else begin
                acc_r   <= {ZERO_W, b_mag_s};
                mcand_r <= a_mag_s;
              end
            end
          end
        end
        RUN: begin
          acc_r <= op_div_r ? div_next_s : mul_next_s;
          cnt_r <= cnt_r + CNT1;
          if (cnt_r == LAST) state_r <= FIX;
        end
        FIX: begin
          hi_r     <= fix_hi_s;
          lo_r     <= fix_lo_s;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          dz_out_r <= dz_r;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dz_out_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (default build, WIDTH=32).
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  muldiv_unit_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef MULDIV_EARLY_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  // Issue one operation from a negedge and wait (bounded) for done; returns results at the done cycle.
  task automatic run_op(input logic div, input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] hi_o, output logic [31:0] lo_o, output logic dz_o,
                        output int lat, output int busy_cnt, output int dz_early);
    bus.start = 1'b1; bus.mul0_div1_sel = div; bus.is_signed = sgn; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0; busy_cnt = 0; dz_early = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.div_by_zero !== 1'b0) dz_early++;
      @(negedge clk);
      lat++;
    end
    hi_o = bus.hi; lo_o = bus.lo; dz_o = bus.div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", bus.hi, 32'h0); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", bus.lo, 32'h0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", bus.div_by_zero); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] h, l; logic dz; int lat, bc, dze;
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, dz, lat, bc, dze);
    total++; if (h !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulu_max_hi got=%h exp=%h", h, 32'hFFFF_FFFE); end
    total++; if (l !== 32'h0000_0001) begin bad++; $display("FAIL mulu_max_lo got=%h exp=%h", l, 32'h1); end
    total++; if (lat !== 33) begin bad++; $display("FAIL mulu_latency got=%0d exp=33", lat); end
    total++; if (bc !== 33) begin bad++; $display("FAIL mulu_busy_cycles got=%0d exp=33", bc); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mulu_busy_at_done got=%b exp=0", bus.busy); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mulu_done_pulse got=%b exp=0", bus.done); end
    total++; if (bus.hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulu_hi_hold got=%h exp=%h", bus.hi, 32'hFFFF_FFFE); end
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0003, h, l, dz, lat, bc, dze);
    total++; if (h !== 32'hFFFF_FFFF) begin bad++; $display("FAIL muls_hi got=%h exp=%h", h, 32'hFFFF_FFFF); end
    total++; if (l !== 32'hFFFF_FFEB) begin bad++; $display("FAIL muls_lo got=%h exp=%h", l, 32'hFFFF_FFEB); end
    @(negedge clk);
    run_op(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, h, l, dz, lat, bc, dze);
    total++; if (h !== 32'h0000_0001 || l !== 32'h0) begin bad++; $display("FAIL mulu_carry got=%h_%h exp=00000001_00000000", h, l); end
    @(negedge clk);
    run_op(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0005, h, l, dz, lat, bc, dze);
    total++; if (h !== 32'h0 || l !== 32'h0) begin bad++; $display("FAIL mul_zero got=%h_%h exp=0_0", h, l); end
    total++; if (lat !== ZLAT) begin bad++; $display("FAIL mul_zero_latency got=%0d exp=%0d", lat, ZLAT); end
    @(negedge clk);
  endtask

  task automatic test_div();
    logic [31:0] h, l; logic dz; int lat, bc, dze;
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, h, l, dz, lat, bc, dze);
    total++; if (l !== 32'hFFFF_FFFD) begin bad++; $display("FAIL divs_lo got=%h exp=%h", l, 32'hFFFF_FFFD); end
    total++; if (h !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divs_hi got=%h exp=%h", h, 32'hFFFF_FFFF); end
    total++; if (lat !== 33) begin bad++; $display("FAIL divs_latency got=%0d exp=33", lat); end
    @(negedge clk);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, h, l, dz, lat, bc, dze);
    total++; if (l !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h exp=%h", l, 32'd14); end
    total++; if (h !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h exp=%h", h, 32'd2); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL divu_dz got=%b exp=0", dz); end
    @(negedge clk);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, h, l, dz, lat, bc, dze);
    total++; if (l !== 32'd3 || h !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divs_negneg got=%h_%h exp=ffffffff_00000003", h, l); end
    @(negedge clk);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, h, l, dz, lat, bc, dze);
    total++; if (l !== 32'h8000_0000 || h !== 32'h0) begin bad++; $display("FAIL divs_overflow got=%h_%h exp=00000000_80000000", h, l); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL divs_overflow_dz got=%b exp=0", dz); end
    @(negedge clk);
  endtask

  task automatic test_div_by_zero();
    logic [31:0] h, l; logic dz; int lat, bc, dze;
    run_op(1'b1, 1'b0, 32'h0000_1234, 32'h0, h, l, dz, lat, bc, dze);
    total++; if (l !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_lo got=%h exp=%h", l, 32'hFFFF_FFFF); end
    total++; if (h !== 32'h0000_1234) begin bad++; $display("FAIL dz_hi got=%h exp=%h", h, 32'h1234); end
    total++; if (dz !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", dz); end
    total++; if (dze !== 0) begin bad++; $display("FAIL dz_early got=%0d exp=0", dze); end
    total++; if (lat !== 33) begin bad++; $display("FAIL dz_latency got=%0d exp=33", lat); end
    @(negedge clk);
    total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL dz_after got=%b exp=0", bus.div_by_zero); end
    run_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'h0, h, l, dz, lat, bc, dze);
    total++; if (h !== 32'hFFFF_FFFB || l !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_signed got=%h_%h exp=fffffffb_ffffffff", h, l); end
    @(negedge clk);
  endtask

  task automatic test_mt_write();
    bus.wr_hi = 1'b1; bus.wd = 32'h0000_AAAA;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    total++; if (bus.hi !== 32'h0000_AAAA) begin bad++; $display("FAIL mthi got=%h exp=%h", bus.hi, 32'hAAAA); end
    bus.wr_lo = 1'b1; bus.wd = 32'h0000_5555;
    @(negedge clk);
    bus.wr_lo = 1'b0;
    total++; if (bus.lo !== 32'h0000_5555 || bus.hi !== 32'h0000_AAAA) begin bad++; $display("FAIL mtlo got=%h_%h exp=0000aaaa_00005555", bus.hi, bus.lo); end
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wd = 32'h1357_9BDF;
    @(negedge clk);
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    total++; if (bus.hi !== 32'h1357_9BDF || bus.lo !== 32'h1357_9BDF) begin bad++; $display("FAIL mt_both got=%h_%h exp=13579bdf_13579bdf", bus.hi, bus.lo); end
  endtask

  task automatic test_start_with_mt();
    logic [31:0] h, l; logic dz; int lat, bc, dze;
    bus.wr_hi = 1'b1; bus.wd = 32'h0000_BEEF;
    bus.start = 1'b1; bus.mul0_div1_sel = 1'b0; bus.is_signed = 1'b0; bus.a = 32'd5; bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0; bus.wr_hi = 1'b0;
    total++; if (bus.hi !== 32'h0000_BEEF) begin bad++; $display("FAIL start_mt_land got=%h exp=%h", bus.hi, 32'hBEEF); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b exp=1", bus.busy); end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'd45) begin bad++; $display("FAIL start_mt_result got=%h_%h exp=00000000_0000002d", bus.hi, bus.lo); end
    // back-to-back: a new start presented in the done cycle is accepted
    run_op(1'b1, 1'b0, 32'd1000, 32'd10, h, l, dz, lat, bc, dze);
    total++; if (l !== 32'd100 || h !== 32'd0) begin bad++; $display("FAIL b2b_result got=%h_%h exp=00000000_00000064", h, l); end
    total++; if (lat !== 33) begin bad++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int lat;
    bus.start = 1'b1; bus.mul0_div1_sel = 1'b0; bus.is_signed = 1'b0; bus.a = 32'd6; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.mul0_div1_sel = 1'b1; bus.a = 32'd99; bus.b = 32'd3;
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wd = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    lat = 6;
    while (bus.done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'd42) begin bad++; $display("FAIL busy_ignore_result got=%h_%h exp=00000000_0000002a", bus.hi, bus.lo); end
    total++; if (lat !== 33) begin bad++; $display("FAIL busy_ignore_latency got=%0d exp=33", lat); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_ignore_no_requeue got=%b exp=0", bus.busy); end
  endtask

  task automatic test_reset_midrun();
    int dones;
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wd = 32'h0000_7777;
    @(negedge clk);
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    bus.start = 1'b1; bus.mul0_div1_sel = 1'b0; bus.is_signed = 1'b0; bus.a = 32'hFFFF_FFFF; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin bad++; $display("FAIL midrun_rst_hilo got=%h_%h exp=0_0", bus.hi, bus.lo); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrun_rst_busy got=%b exp=0", bus.busy); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done !== 1'b0) dones++;
      @(negedge clk);
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL midrun_rst_no_done got=%0d exp=0", dones); end
  endtask

  initial begin
    bus.start = 1'b0; bus.mul0_div1_sel = 1'b0; bus.is_signed = 1'b0;
    bus.a = 32'h0; bus.b = 32'h0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wd = 32'h0;
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_mt_write();
    test_start_with_mt();
    test_busy_ignore();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
